// File: rtl/handshake_sender_pkg.sv
// Shared definitions for the four-phase req/ack crossing (sender and receiver sides).
// No logic; state encoding and default depths only.
// Receive-side blocks reuse the default constants below.
package handshake_sender_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_t;

  localparam int HS_SYNC_LEN_DEF = 4;
  localparam int HS_TIMEOUT_DEF  = 1024;

endpackage

// File: rtl/handshake_sender_sync_chain.sv
// 1-bit synchronizer shift register for an asynchronous level input.
// Latency: DEPTH clk edges from capture to q.
// Backpressure: none; free-running on every edge.
module sync_chain
  import handshake_sender_pkg::*;
#(
  parameter int DEPTH = HS_SYNC_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/handshake_sender.sv
// Four-phase req/ack transmitter into an unrelated clock domain; optional watchdog under HS_TIMEOUT_EN.
// Latency: req_out rises the edge after accept; minimum accept-to-tx_done is 2*SYNC_LEN+2 cycles plus far side.
// Backpressure: tx_ready low outside IDLE and while synchronized ack is high; no buffering.
module handshake_sender
  import handshake_sender_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_LEN    = HS_SYNC_LEN_DEF,
  parameter int TIMEOUT_CYC = HS_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              tx_done,
  output logic              err_timeout
);

  hs_state_t state;
  hs_state_t state_nxt;
  logic      ack_s;
  logic      accept;
  logic      req_expire;
  logic      rel_expire;

  sync_chain #(
    .DEPTH (SYNC_LEN)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_in),
    .q   (ack_s)
  );

  // A stale high ack must never be answered by a new request.
  assign tx_ready = (state == IDLE) && !ack_s;
  assign accept   = tx_valid && tx_ready;

`ifdef HS_TIMEOUT_EN
  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_WARN = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) begin
      wd_cnt <= '0;
    end else if ((state != IDLE) && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign req_expire = (state == REQ) && (wd_cnt == CNT_MAX);
  // REL flags the edge on which the counter reaches its saturation value, so it fires once.
  assign rel_expire = (state == REL) && ack_s && (wd_cnt == CNT_WARN);
`else
  assign req_expire = 1'b0;
  assign rel_expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (ack_s || req_expire) state_nxt = REL;
      REL:     if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_out     <= 1'b0;
      data_out    <= '0;
      tx_done     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_out     <= (state_nxt == REQ);
      tx_done     <= (state == REL) && (state_nxt == IDLE);
      err_timeout <= (req_expire && !ack_s) || rel_expire;
      if (accept) begin
        data_out <= tx_data;
      end
    end
  end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender; the far side is played inline by the stimulus sequence.
// Covers reset, single and back-to-back transfers, stale ack, reset mid-transfer, watchdog or no-watchdog build.
module tb_handshake_sender;

  localparam int DW = 8;
  localparam int SL = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          ack_in = 1'b0;
  logic          tx_done;
  logic          err_timeout;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic          xfer_open = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] rx[$];

  handshake_sender #(
    .DATA_W      (DW),
    .SYNC_LEN    (SL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_in      (ack_in),
    .tx_done     (tx_done),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_done === 1'b1) done_cnt++;
    if (xfer_open) begin
      check("data_stable", data_out, exp_data);
      if (tx_done !== 1'b1) check("ready_low_busy", tx_ready, 1'b0);
    end
  endtask

  task automatic xfer_start(input logic [DW-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    check("ready_before_accept", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    check("req_rise", req_out, 1'b1);
    check("data_latch", data_out, d);
    exp_data  = d;
    xfer_open = 1'b1;
  endtask

  // Far side: ack 3 cycles after req seen, release 3 cycles after req drops.
  task automatic xfer_finish();
    int n;
    int d0;
    repeat (3) tick();
    check("req_hold", req_out, 1'b1);
    rx.push_back(data_out);
    ack_in = 1'b1;
    n = 0;
    while (req_out === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_fall_lat", n, SL + 1);
    repeat (3) tick();
    ack_in = 1'b0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      tick();
      n++;
    end
    check("done_lat", n, SL + 1);
    check("ready_at_done", tx_ready, 1'b1);
    xfer_open = 1'b0;
  endtask

  initial begin
    int n;
    int d0;
    int bad_req;
    int bad_err;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check("rst_req", req_out, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_ready", tx_ready, 1'b1);
    rst = 1'b0;

    // Basic transfer
    d0 = done_cnt;
    xfer_start(8'hA5);
    xfer_finish();
    tick();
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_done_low", tx_done, 1'b0);
    check("basic_rx", rx[0], 8'hA5);

    // Back-to-back: each start follows the done cycle directly
    rx.delete();
    d0 = done_cnt;
    xfer_start(8'h01);
    xfer_finish();
    xfer_start(8'h02);
    xfer_finish();
    xfer_start(8'h03);
    xfer_finish();
    check("b2b_done_cnt", done_cnt - d0, 3);
    check("b2b_rx_len", rx.size(), 3);
    if (rx.size() == 3) begin
      check("b2b_rx0", rx[0], 8'h01);
      check("b2b_rx1", rx[1], 8'h02);
      check("b2b_rx2", rx[2], 8'h03);
    end

    // Stale ack after reset
    rst    = 1'b1;
    ack_in = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("stale_first_ready", tx_ready, 1'b1);
    repeat (SL) tick();
    check("stale_blocks", tx_ready, 1'b0);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stale_no_req", req_out, 1'b0);
    end
    ack_in = 1'b0;
    n = 0;
    while (tx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("stale_ready_lat", n, SL);
    check("stale_req_still_low", req_out, 1'b0);
    tick();
    tx_valid = 1'b0;
    check("stale_req_rise", req_out, 1'b1);
    check("stale_data", data_out, 8'h5A);
    exp_data  = 8'h5A;
    xfer_open = 1'b1;
    xfer_finish();

    // Reset while in REQ with ack on its way
    xfer_start(8'h77);
    repeat (3) tick();
    ack_in = 1'b1;
    repeat (2) tick();
    xfer_open = 1'b0;
    rst = 1'b1;
    tick();
    check("mid_rst_req", req_out, 1'b0);
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_done", tx_done, 1'b0);
    check("mid_rst_ready", tx_ready, 1'b1);
    rst = 1'b0;
    repeat (SL) tick();
    check("mid_ack_blocks", tx_ready, 1'b0);
    tx_data  = 8'h88;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_accept", req_out, 1'b0);
    end
    ack_in = 1'b0;
    n = 0;
    while (req_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tx_valid = 1'b0;
    check("mid_accept_lat", n, SL + 1);
    check("mid_data", data_out, 8'h88);
    exp_data  = 8'h88;
    xfer_open = 1'b1;
    xfer_finish();

`ifdef HS_TIMEOUT_EN
    // Watchdog with ack_in held low
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("to_req_rise", req_out, 1'b1);
    bad_err = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (err_timeout !== 1'b0) bad_err++;
    end
    check("to_no_early_err", bad_err, 0);
    check("to_req_before", req_out, 1'b1);
    tick();
    check("to_err_pulse", err_timeout, 1'b1);
    check("to_req_fall", req_out, 1'b0);
    tick();
    check("to_done", tx_done, 1'b1);
    check("to_err_once", err_timeout, 1'b0);
    check("to_ready", tx_ready, 1'b1);
    tick();
    check("to_done_low", tx_done, 1'b0);
`else
    // No watchdog: the sender waits indefinitely
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("wait_req_rise", req_out, 1'b1);
    bad_req = 0;
    bad_err = 0;
    repeat (5000) begin
      tick();
      if (req_out !== 1'b1) bad_req++;
      if (err_timeout !== 1'b0) bad_err++;
    end
    check("wait_req_held", bad_req, 0);
    check("wait_no_err", bad_err, 0);
    check("wait_data", data_out, 8'hC3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/handshake_sender.md
# handshake_sender

Transmit side of the four-phase req/ack crossing used to hand words from the `clk` domain to logic running on an unrelated clock. It latches one word from a local valid/ready source, drives a level `req_out` plus a stable `data_out` to the far side, and synchronizes the far side's asynchronous `ack_in` before using it. It is the partner of the receive-side synchronizer chains already used on asynchronous inputs.

## Interface
- `DATA_W`, 8, width of the transferred word
- `SYNC_LEN`, 4, flip-flop stages on `ack_in` (minimum 2)
- `TIMEOUT_CYC`, 1024, watchdog limit in `clk` cycles (used only with `HS_TIMEOUT_EN`)
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `tx_valid`  in  1  local source has a word
- `tx_ready`  out  1  sender accepts a word this cycle
- `tx_data`  in  DATA_W  word, sampled on accept
- `req_out`  out  1  registered request level to the far domain
- `data_out`  out  DATA_W  registered word, stable while a transfer is open
- `ack_in`  in  1  asynchronous acknowledge from the far domain
- `tx_done`  out  1  one-cycle pulse when a transfer completes
- `err_timeout`  out  1  one-cycle pulse on watchdog expiry (tied 0 without `HS_TIMEOUT_EN`)

## Operation
- `ack_s` is `ack_in` passed through `SYNC_LEN` flops; only `ack_s` is used internally.
- States:
  - IDLE: `req_out`=0. `tx_ready` = IDLE && !`ack_s`. On `tx_valid && tx_ready`: `data_out`<=`tx_data`, `req_out`<=1, go to REQ.
  - REQ: hold `req_out`=1. When `ack_s`=1: `req_out`<=0, go to REL.
  - REL: hold `data_out`. When `ack_s`=0: pulse `tx_done`, go to IDLE.
- `data_out` changes only on accept, so it is stable from the `req_out` rise until the synchronized `ack_in` fall.
- An `ack_in` that is high while in IDLE (stale, or after reset) blocks `tx_ready` until it falls. No transfer starts against a high ack.
- A `tx_valid` pulse that is not accepted is not remembered; the source holds `tx_valid` until it sees `tx_ready`.
- Reset mid-transfer: all outputs return to their reset values on the next edge, including `req_out`=0. The first new accept waits for `ack_s`=0.
- Reset values: `req_out`=0, `data_out`=0, `tx_done`=0, `err_timeout`=0, state IDLE, sync flops 0, so `tx_ready`=1 in the first cycle after reset.

## Timing
- Accept at edge N: `req_out`=1 and `data_out` are valid after edge N.
- An `ack_in` rise is seen in state logic `SYNC_LEN` edges after capture. `req_out` falls one edge after that.
- `tx_done` pulses on the edge that returns the state to IDLE. `tx_ready` can be high in the same cycle, so back-to-back accepts are possible.
- Minimum transfer length, from accept to `tx_done`: 2·`SYNC_LEN`+2 cycles, plus far-side latency.
- Throughput is at most one word per round trip. There is no buffering.

## Configuration
- `HS_TIMEOUT_EN` defined:
  - A counter of width clog2(`TIMEOUT_CYC`) clears on every state change and increments while in REQ or REL.
  - REQ reaching `TIMEOUT_CYC`-1: `req_out`<=0, go to REL, pulse `err_timeout`.
  - REL reaching `TIMEOUT_CYC`-1: pulse `err_timeout` once, then saturate. Stay in REL until `ack_s`=0, then pulse `tx_done`.
- `HS_TIMEOUT_EN` undefined: no counter is built, `err_timeout` is constant 0, and the sender waits indefinitely.

## Structure
- Shared package holds:
  - the state enum `hs_state_t` (IDLE, REQ, REL);
  - the default constants `HS_SYNC_LEN_DEF`=4 and `HS_TIMEOUT_DEF`=1024, reused by the receive-side block.
- One sub-module, `sync_chain`:
  - parameterized depth, 1-bit, shift register on `clk`, cleared by `rst`;
  - instantiated once for `ack_in`.

## Test plan
- Basic transfer: reset, `tx_data`=8'hA5 with `tx_valid`. Far-side model raises `ack_in` 3 cycles after seeing `req_out`, and drops it 3 cycles after `req_out` falls.
  - Required: `data_out`=8'hA5 stable throughout, `tx_ready`=0 until done, exactly one `tx_done`, `req_out` falls exactly `SYNC_LEN`+1 edges after `ack_in` rises.
- Back-to-back: 8'h01, 8'h02, 8'h03 streamed through the same far-side model.
  - Required: three `tx_done` pulses, values arrive in order, `data_out` never changes while `req_out`=1 or `ack_s`=1.
- Stale ack: hold `ack_in`=1 for 10 cycles after reset while `tx_valid`=1.
  - Required: `tx_ready`=0 and no `req_out` rise until `SYNC_LEN` cycles after `ack_in` falls.
- Reset mid-transfer: assert `rst` while in REQ, release, then apply `tx_valid`.
  - Required: `req_out`=0 on the edge after reset, and no new accept while `ack_s`=1.
- Timeout (`HS_TIMEOUT_EN`, `TIMEOUT_CYC`=16): `ack_in` tied to 0.
  - Required: `err_timeout` pulses once 16 cycles after accept, `req_out` falls with it, state returns to IDLE with `tx_done` one cycle later.
- Build without `HS_TIMEOUT_EN`, `ack_in`=0 for 5000 cycles.
  - Required: `req_out` stays 1 and `err_timeout` stays 0 throughout.
